// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: a clock-enable divider steps the LED bank through
// rotate-left, rotate-right, bounce or binary-count patterns.
module led_pattern_seq #(
   parameter int WIDTH    = 4,
   parameter int TICK_DIV = 1250000
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [1:0]       speed,
   output logic [WIDTH-1:0] led,
   output logic             tick,
   output logic             wrap
);

   localparam int CW = $clog2(TICK_DIV);

   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   logic [CW-1:0]    count, count_next;
   dir_t             dir, dir_next;
   logic             started, started_next;
   logic [1:0]       mode_q, mode_q_next;
   logic [WIDTH-1:0] led_next;
   logic             wrap_next;
   logic             step;
   logic [31:0]      period_m1;

   function automatic logic [WIDTH-1:0] init_pattern(input logic [1:0] m);
      case (m)
         2'd1:    return {1'b1, {(WIDTH-1){1'b0}}};
         2'd3:    return '0;
         default: return WIDTH'(1);
      endcase
   endfunction

   // >= rather than == so a switch to a shorter period never overruns the counter
   assign period_m1 = (32'(TICK_DIV) >> speed) - 32'd1;
   assign step      = en && (32'(count) >= period_m1);

   always_comb begin
      count_next   = count;
      led_next     = led;
      dir_next     = dir;
      started_next = started;
      mode_q_next  = mode_q;
      wrap_next    = 1'b0;

      if (en)
         count_next = step ? '0 : count + CW'(1);

      if (step) begin
         if (!started || (mode != mode_q)) begin
            led_next     = init_pattern(mode);
            dir_next     = DIR_UP;
            mode_q_next  = mode;
            started_next = 1'b1;
         end else begin
            case (mode_q)
               2'd0: begin
                  led_next  = {led[WIDTH-2:0], led[WIDTH-1]};
                  wrap_next = led[WIDTH-1];
               end
               2'd1: begin
                  led_next  = {led[0], led[WIDTH-1:1]};
                  wrap_next = led[0];
               end
               2'd2: begin
                  // end positions are shown once; the turn happens on arrival
                  if (dir == DIR_UP) begin
                     led_next = led << 1;
                     if (led_next[WIDTH-1])
                        dir_next = DIR_DOWN;
                  end else begin
                     led_next = led >> 1;
                     if (led_next[0]) begin
                        dir_next  = DIR_UP;
                        wrap_next = 1'b1;
                     end
                  end
               end
               default: begin
                  led_next  = led + WIDTH'(1);
                  wrap_next = &led;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         count   <= '0;
         led     <= '0;
         dir     <= DIR_UP;
         started <= 1'b0;
         mode_q  <= 2'd0;
         tick    <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         count   <= count_next;
         led     <= led_next;
         dir     <= dir_next;
         started <= started_next;
         mode_q  <= mode_q_next;
         tick    <= step;
         wrap    <= wrap_next;
      end
   end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: directed pattern scenarios plus randomized control,
// every cycle compared against a position/arithmetic model of the LED patterns.
module tb_led_pattern_seq;

   localparam int WIDTH    = 4;
   localparam int TICK_DIV = 8;

   logic             clk = 1'b0;
   logic             nrst;
   logic             en;
   logic [1:0]       mode;
   logic [1:0]       speed;
   logic [WIDTH-1:0] led;
   logic             tick;
   logic             wrap;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int m_phase, m_led, m_pos, m_mode;
   bit m_started, m_tick, m_wrap;

   led_pattern_seq #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .nrst(nrst), .en(en), .mode(mode), .speed(speed),
      .led(led), .tick(tick), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int bounce_led(input int p);
      return 1 << ((p < WIDTH) ? p : (2*WIDTH - 2 - p));
   endfunction

   task automatic model_reset();
      m_phase = 0; m_led = 0; m_pos = 0; m_mode = 0;
      m_started = 0; m_tick = 0; m_wrap = 0;
   endtask

   // one rising edge of the model, using the inputs currently applied
   task automatic model_edge();
      int p;
      p = TICK_DIV >> speed;
      m_tick = 0;
      m_wrap = 0;
      if (!en) return;
      if (m_phase < p - 1) begin
         m_phase++;
         return;
      end
      m_phase = 0;
      m_tick  = 1;
      if (!m_started || (int'(mode) != m_mode)) begin
         m_started = 1;
         m_mode    = int'(mode);
         m_pos     = 0;
         m_led     = (mode == 2'd1) ? (1 << (WIDTH-1)) : (mode == 2'd3) ? 0 : 1;
      end else begin
         case (m_mode)
            0: begin
               m_wrap = (m_led >= (1 << (WIDTH-1)));
               m_led  = (m_led * 2) % (1 << WIDTH) + (m_wrap ? 1 : 0);
            end
            1: begin
               m_wrap = (m_led % 2) == 1;
               m_led  = m_led / 2 + (m_wrap ? (1 << (WIDTH-1)) : 0);
            end
            2: begin
               m_pos  = (m_pos + 1) % (2*WIDTH - 2);
               m_led  = bounce_led(m_pos);
               m_wrap = (m_pos == 0);
            end
            default: begin
               m_wrap = (m_led == (1 << WIDTH) - 1);
               m_led  = (m_led + 1) % (1 << WIDTH);
            end
         endcase
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check("led",  32'(led),  32'(m_led));
      check("tick", 32'(tick), 32'(m_tick));
      check("wrap", 32'(wrap), 32'(m_wrap));
   endtask

   task automatic wait_tick(input int limit, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!tick && n < limit);
      check("tick_within_limit", 32'(tick), 32'd1);
   endtask

   // short asynchronous reset pulse between clock edges
   task automatic reset_pulse();
      #2 nrst = 1'b0;
      #1;
      check("async_rst_led",  32'(led),  32'd0);
      check("async_rst_tick", 32'(tick), 32'd0);
      check("async_rst_wrap", 32'(wrap), 32'd0);
      #1 nrst = 1'b1;
      model_reset();
   endtask

   initial begin
      int n, k;
      logic [WIDTH-1:0] held;
      int exp_rl[4]    = '{2, 4, 8, 1};
      int exp_rlw[4]   = '{0, 0, 0, 1};
      int exp_mc[5]    = '{8, 4, 2, 1, 8};
      int exp_mcw[5]   = '{0, 0, 0, 0, 1};
      int exp_bn[7]    = '{2, 4, 8, 4, 2, 1, 2};
      int exp_bnw[7]   = '{0, 0, 0, 0, 0, 1, 0};

      nrst = 1'b0; en = 1'b0; mode = 2'd0; speed = 2'd0;
      model_reset();
      #12;
      check("reset_led",  32'(led),  32'd0);
      check("reset_tick", 32'(tick), 32'd0);
      check("reset_wrap", 32'(wrap), 32'd0);
      nrst = 1'b1;
      en   = 1'b1;

      // rotate-left
      wait_tick(20, n);
      check("first_step_latency", n, 8);
      check("rotl_load", 32'(led), 32'd1);
      for (int i = 0; i < 4; i++) begin
         wait_tick(20, n);
         check("rotl_period", n, 8);
         check("rotl_led", 32'(led), exp_rl[i]);
         check("rotl_wrap", 32'(wrap), exp_rlw[i]);
      end

      // mode change 0 -> 1 while showing 0100
      k = 0;
      do begin
         wait_tick(20, n);
         k++;
      end while (led != 4'b0100 && k < 6);
      check("reach_0100", 32'(led), 32'd4);
      mode = 2'd1;
      for (int i = 0; i < 5; i++) begin
         wait_tick(20, n);
         check("modechg_led", 32'(led), exp_mc[i]);
         check("modechg_wrap", 32'(wrap), exp_mcw[i]);
      end

      // bounce
      mode = 2'd2;
      wait_tick(20, n);
      check("bounce_load", 32'(led), 32'd1);
      for (int i = 0; i < 7; i++) begin
         wait_tick(20, n);
         check("bounce_led", 32'(led), exp_bn[i]);
         check("bounce_wrap", 32'(wrap), exp_bnw[i]);
      end

      // binary count
      mode = 2'd3;
      wait_tick(20, n);
      check("count_load", 32'(led), 32'd0);
      for (int r = 0; r < 2; r++) begin
         k = 0;
         do begin
            wait_tick(20, n);
            k++;
         end while (!wrap && k < 40);
         check("count_ticks_per_wrap", k, 16);
         check("count_wrap_led", 32'(led), 32'd0);
      end

      // pause with the divider at 3
      for (int i = 0; i < 3; i++) cycle();
      en   = 1'b0;
      held = led;
      for (int i = 0; i < 20; i++) begin
         cycle();
         check("pause_led", 32'(led), 32'(held));
         check("pause_tick", 32'(tick), 32'd0);
      end
      en = 1'b1;
      wait_tick(20, n);
      check("resume_latency", n, 5);

      // fastest speed: a step every cycle
      speed = 2'd3;
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("fast_tick", 32'(tick), 32'd1);
      end

      // asynchronous reset mid-pattern, then reload of the current mode
      reset_pulse();
      speed = 2'd0;
      mode  = 2'd1;
      wait_tick(20, n);
      check("post_reset_latency", n, 8);
      check("post_reset_load", 32'(led), 32'd8);
      check("post_reset_wrap", 32'(wrap), 32'd0);

      // randomized control
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) en = ~en;
         if ($urandom_range(0, 3) != 0 && !en) en = 1'b1;
         if ($urandom_range(0, 40) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 60) == 0) speed = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 200) == 0) reset_pulse();
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
